cd_sector_fetch: RTL and testbench

- Fetches one raw CD sector from the HPS disc-image interface and stores it in a local word buffer.
- Replays the buffered sector to the CDIC as a valid/ready word stream.
- Sits directly upstream of cdic: owns the cd_hps_* handshake at the top level and presents cdic with a clean, fully buffered sector.
- Detects short and overlong HPS transfers and reports them as sticky fail flags.

---
 rtl/cd_sector_fetch.sv | 136 +++++++++++++
 tb/tb_cd_sector_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cd_sector_fetch.sv
// rtl/cd_sector_fetch.sv - fetch one raw CD sector from HPS into a word buffer and replay it to cdic
// Optional CD_FETCH_BYTESWAP_EN: byte-swap each HPS word before it is stored.
module cd_sector_fetch #(
   parameter int WORDS_PER_SECTOR = 1176,
   parameter int TIMEOUT_CYCLES   = 300000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sector_req,
   input  logic [31:0] lba_in,
   output logic        busy,
   output logic [31:0] cd_hps_lba,
   output logic        cd_hps_req,
   input  logic        cd_hps_ack,
   input  logic        cd_hps_data_valid,
   input  logic [15:0] cd_hps_data,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        sector_done,
   output logic        fail_not_enough_words,
   output logic        fail_too_much_data
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [10:0]   FULL = 11'(WORDS_PER_SECTOR);
   localparam logic [10:0]   LAST = 11'(WORDS_PER_SECTOR - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, DRAIN} state_t;
   state_t state, state_next;

   logic [15:0]   mem [0:2047];
   logic [15:0]   ram_q;
   logic [15:0]   wr_word;
   logic [10:0]   count;
   logic [10:0]   rd_ptr;
   logic [10:0]   rd_addr;
   logic [TW-1:0] timeout;
   logic          full;
   logic          timed_out;
   logic          wr_en;
   logic          consume;
   logic          last_consume;

`ifdef CD_FETCH_BYTESWAP_EN
   assign wr_word = {cd_hps_data[7:0], cd_hps_data[15:8]};
`else
   assign wr_word = cd_hps_data;
`endif

   always_comb begin
      full         = (count == FULL);
      timed_out    = (timeout == TMAX);
      consume      = (state == DRAIN) && rd_valid && rd_ready;
      last_consume = consume && (rd_ptr == LAST);
      wr_en        = cd_hps_data_valid && !full &&
                     (((state == REQUEST) && cd_hps_ack) || ((state == RECEIVE) && !timed_out));
      // Look one word ahead on a handshake so the RAM output already holds the next word.
      rd_addr      = consume ? rd_ptr + 11'd1 : rd_ptr;
      rd_data      = (rd_valid && (rd_ptr < count)) ? ram_q : 16'h0000;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sector_req) state_next = REQUEST;
         REQUEST: if (cd_hps_ack) state_next = RECEIVE;
         RECEIVE: if (full || timed_out) state_next = DRAIN;
         DRAIN:   if (last_consume) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[count] <= wr_word;
      ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy                  <= 1'b0;
         cd_hps_lba            <= 32'h0;
         cd_hps_req            <= 1'b0;
         rd_valid              <= 1'b0;
         sector_done           <= 1'b0;
         fail_not_enough_words <= 1'b0;
         fail_too_much_data    <= 1'b0;
         count                 <= 11'd0;
         rd_ptr                <= 11'd0;
         timeout               <= '0;
      end else begin
         sector_done <= 1'b0;
         if (wr_en) count <= count + 11'd1;
         case (state)
            IDLE: begin
               if (sector_req) begin
                  cd_hps_lba            <= lba_in;
                  cd_hps_req            <= 1'b1;
                  busy                  <= 1'b1;
                  count                 <= 11'd0;
                  rd_ptr                <= 11'd0;
                  timeout               <= '0;
                  fail_not_enough_words <= 1'b0;
                  fail_too_much_data    <= 1'b0;
               end
            end
            REQUEST: begin
               if (cd_hps_ack) cd_hps_req <= 1'b0;
            end
            RECEIVE: begin
               if (wr_en)           timeout <= '0;
               else if (!timed_out) timeout <= timeout + 1'b1;
               if (timed_out && !full) fail_not_enough_words <= 1'b1;
               if (cd_hps_data_valid && full) fail_too_much_data <= 1'b1;
            end
            DRAIN: begin
               if (cd_hps_data_valid) fail_too_much_data <= 1'b1;
               if (last_consume) begin
                  rd_valid    <= 1'b0;
                  busy        <= 1'b0;
                  sector_done <= 1'b1;
               end else begin
                  rd_valid <= 1'b1;
                  if (consume) rd_ptr <= rd_ptr + 11'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cd_sector_fetch.sv
// tb/tb_cd_sector_fetch.sv - scoreboard bench for cd_sector_fetch
module tb_cd_sector_fetch;
   localparam int WPS = 1176;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sector_req = 1'b0;
   logic [31:0] lba_in = 32'h0;
   logic        busy;
   logic [31:0] cd_hps_lba;
   logic        cd_hps_req;
   logic        cd_hps_ack = 1'b0;
   logic        cd_hps_data_valid = 1'b0;
   logic [15:0] cd_hps_data = 16'h0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b1;
   logic        sector_done;
   logic        fail_not_enough_words;
   logic        fail_too_much_data;

   int errors = 0;
   int checks = 0;
   int ready_mode = 0;
   int cyc = 0;
   logic [15:0] exp_q[$];
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0;
   bit          expect_done = 1'b0;

   cd_sector_fetch #(.WORDS_PER_SECTOR(WPS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .sector_req(sector_req), .lba_in(lba_in), .busy(busy),
      .cd_hps_lba(cd_hps_lba), .cd_hps_req(cd_hps_req), .cd_hps_ack(cd_hps_ack),
      .cd_hps_data_valid(cd_hps_data_valid), .cd_hps_data(cd_hps_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .sector_done(sector_done),
      .fail_not_enough_words(fail_not_enough_words), .fail_too_much_data(fail_too_much_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [15:0] stored(input logic [15:0] w);
`ifdef CD_FETCH_BYTESWAP_EN
      return {w[7:0], w[15:8]};
`else
      return w;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         case (ready_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ((cyc / 3) % 2) == 0;
            default: rd_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_stall  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (expect_done) begin
            chk("sector_done_after_last", {31'd0, sector_done}, 32'd1);
            chk("rd_valid_drop_at_done", {31'd0, rd_valid}, 32'd0);
            expect_done = 1'b0;
         end
         if (prev_stall) begin
            chk("stall_valid_hold", {31'd0, rd_valid}, 32'd1);
            chk("stall_data_hold", {16'd0, rd_data}, {16'd0, prev_data});
         end
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {16'd0, rd_data}, 32'hFFFF_FFFF);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               chk("rd_data", {16'd0, rd_data}, {16'd0, e});
               if (exp_q.size() == 0) expect_done = 1'b1;
            end
         end
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
      end
   end

   // Issue a request and deliver nwords (sequential or random) with optional gaps.
   task automatic start_sector(input logic [31:0] lba, input int nwords, input int ack_delay,
                               input bit ack_word, input bit seq, input int max_gap,
                               input bit poke_req, input bit first_a1b2);
      logic [15:0] words[$];
      int i;
      for (int k = 0; k < nwords; k++) words.push_back(seq ? 16'(k) : 16'($urandom));
      if (first_a1b2) words[0] = 16'hA1B2;
      for (int k = 0; k < WPS; k++) exp_q.push_back(k < nwords ? stored(words[k]) : 16'h0000);
      sector_req = 1'b1;
      lba_in = lba;
      tick();
      sector_req = 1'b0;
      lba_in = $urandom;
      chk("cd_hps_lba_latched", cd_hps_lba, lba);
      chk("cd_hps_req_rise", {31'd0, cd_hps_req}, 32'd1);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      chk("fail_flags_cleared", {30'd0, fail_not_enough_words, fail_too_much_data}, 32'd0);
      for (int k = 0; k < ack_delay; k++) begin
         tick();
         chk("cd_hps_req_hold", {31'd0, cd_hps_req}, 32'd1);
      end
      cd_hps_ack = 1'b1;
      i = 0;
      if (ack_word) begin
         cd_hps_data_valid = 1'b1;
         cd_hps_data = words[0];
         i = 1;
      end
      tick();
      cd_hps_ack = 1'b0;
      cd_hps_data_valid = 1'b0;
      chk("cd_hps_req_drop", {31'd0, cd_hps_req}, 32'd0);
      for (; i < nwords; i++) begin
         cd_hps_data_valid = 1'b1;
         cd_hps_data = words[i];
         if (poke_req && i == 500) begin
            sector_req = 1'b1;
            lba_in = 32'hDEAD_BEEF;
         end
         tick();
         if (poke_req && i == 500) begin
            sector_req = 1'b0;
            chk("ignored_req_lba", cd_hps_lba, lba);
         end
         cd_hps_data_valid = 1'b0;
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      end
      cd_hps_data_valid = 1'b0;
   endtask

   task automatic finish_sector(input int nwords);
      int k;
      for (k = 0; k < 20000 && !sector_done; k++) tick();
      chk("sector_done_seen", {31'd0, sector_done}, 32'd1);
      chk("busy_drop", {31'd0, busy}, 32'd0);
      chk("rd_valid_low", {31'd0, rd_valid}, 32'd0);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("fail_not_enough_words", {31'd0, fail_not_enough_words}, {31'd0, nwords < WPS});
      chk("fail_too_much_data", {31'd0, fail_too_much_data}, {31'd0, nwords > WPS});
      exp_q.delete();
      tick();
      chk("sector_done_pulse_width", {31'd0, sector_done}, 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_req", {31'd0, cd_hps_req}, 32'd0);
      chk("reset_lba", cd_hps_lba, 32'd0);
      chk("reset_rd", {15'd0, rd_valid, rd_data}, 32'd0);
      chk("reset_flags", {29'd0, sector_done, fail_not_enough_words, fail_too_much_data}, 32'd0);
      reset = 1'b0;
      tick();

      ready_mode = 0;
      start_sector(32'h0000_1234, WPS, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      finish_sector(WPS);

      ready_mode = 1;
      start_sector(32'h0000_1234, WPS, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      finish_sector(WPS);

      ready_mode = 2;
      start_sector(32'h0001_0000 + $urandom_range(0, 255), 1000, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      finish_sector(1000);

      ready_mode = 0;
      start_sector(32'h0000_4242, 1180, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      finish_sector(1180);

      ready_mode = 2;
      start_sector(32'h0000_0777, 1180, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      repeat (50) tick();
      chk("overflow_flag_before_reset", {31'd0, fail_too_much_data}, 32'd1);
      chk("busy_mid_drain", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("async_reset_flags", {30'd0, fail_not_enough_words, fail_too_much_data}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      sector_req = 1'b1;
      lba_in = 32'h0000_0099;
      tick();
      sector_req = 1'b0;
      chk("req_before_reset", {31'd0, cd_hps_req}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_hps_req", {31'd0, cd_hps_req}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();

      start_sector(32'h0000_5555, WPS, 3, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      finish_sector(WPS);

      ready_mode = 1;
      start_sector($urandom, WPS, 4, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      finish_sector(WPS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
